// File: rtl/mem_arbiter_pkg.sv
// Shared types and reset values for the unified instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_e;

  localparam arb_state_e STATE_RST      = ARB_IDLE;
  localparam arb_owner_e OWNER_RST      = OWN_IF;
  // last_owner resets to D so the first contended round-robin grant goes to fetch
  localparam arb_owner_e LAST_OWNER_RST = OWN_D;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave is the arbiter view,
// master is the surrounding requesters plus memory.
interface mem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);

  logic              if_req_i;
  logic [AWIDTH-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DWIDTH-1:0] if_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [AWIDTH-1:0] d_addr_i;
  logic [DWIDTH-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DWIDTH-1:0] d_rdata_o;

  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_data_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, busy_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_data_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, busy_o
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between fetch and data requests.
// MEM_ARBITER_RR_EN: alternate on contention; otherwise data always beats fetch.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_e last_owner,
  output logic       any_req,
  output arb_owner_e winner
);

  assign any_req = if_req | d_req;

`ifdef MEM_ARBITER_RR_EN
  always_comb begin
    winner = OWN_IF;
    if (if_req && d_req) begin
      winner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end
`else
  arb_owner_e unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = OWN_IF;
    if (d_req) begin
      winner = OWN_D;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch reads and data loads/stores.
// Arbitration policy selected by MEM_ARBITER_RR_EN (see arb_pick).
//
// state    | meaning
// ARB_IDLE | grant at most one request; stores complete here
// ARB_RESP | read outstanding; owner's rvalid driven from mem_data_i
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e        state;
  arb_owner_e        owner;
  arb_owner_e        last_owner;
  arb_owner_e        winner;
  logic              any_req;

  logic              if_gnt, d_gnt, rd_en, wr_en;
  logic              if_rvalid, d_rvalid, busy;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_data, if_rdata, d_rdata;

  arb_pick u_pick (
    .if_req     (bus.if_req_i),
    .d_req      (bus.d_req_i),
    .last_owner (last_owner),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Everything is forced low during reset, including the combinational grant path
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    busy      = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    if_rdata  = '0;
    d_rdata   = '0;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            if (winner == OWN_D) begin
              d_gnt    = 1'b1;
              mem_addr = bus.d_addr_i;
              mem_data = bus.d_wdata_i;
              wr_en    = bus.d_we_i;
              rd_en    = ~bus.d_we_i;
            end else begin
              if_gnt   = 1'b1;
              mem_addr = bus.if_addr_i;
              rd_en    = 1'b1;
            end
          end
        end
        ARB_RESP: begin
          busy = 1'b1;
          if (owner == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = bus.mem_data_i;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = bus.mem_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STATE_RST;
      owner      <= OWNER_RST;
      last_owner <= LAST_OWNER_RST;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            last_owner <= winner;
            if (winner == OWN_IF || !bus.d_we_i) begin
              state <= ARB_RESP;
              owner <= winner;
            end
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.if_gnt_o       = if_gnt;
  assign bus.d_gnt_o        = d_gnt;
  assign bus.mem_read_en_o  = rd_en;
  assign bus.mem_write_en_o = wr_en;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.mem_data_o     = mem_data;
  assign bus.if_rvalid_o    = if_rvalid;
  assign bus.if_rdata_o     = if_rdata;
  assign bus.d_rvalid_o     = d_rvalid;
  assign bus.d_rdata_o      = d_rdata;
  assign bus.busy_o         = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus protocol-respecting random traffic,
// checked every cycle against a transaction-level model; honours MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

  localparam logic [31:0] BASE = 32'h01000000;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus();
  mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] init_word(int i);
    if (i == 0) return 32'h00500093;
    return (32'(i) * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  // Memory behaviour: registered read, one cycle latency
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      if (bus.mem_write_en_o) mem[bus.mem_addr_o[9:2]] <= bus.mem_data_o;
      if (bus.mem_read_en_o)  bus.mem_data_i <= mem[bus.mem_addr_o[9:2]];
    end
  end

  // Reference model: pending read (if any), its owner and data, last grantee, shadow memory
  bit          m_pend;
  bit          m_own_d;
  bit          m_last_d;
  logic [31:0] m_data;
  logic [31:0] shadow [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [31:0] da,
                       input logic [31:0] dwd, output bit gi, output bit gd);
    bit e_gi, e_gd, e_re, e_we, e_iv, e_dv, e_busy, win_d;
    logic [31:0] e_addr, e_data, e_ird, e_drd;
    @(posedge clk); #1;
    rst = r;
    bus.if_req_i = ir; bus.if_addr_i = ia;
    bus.d_req_i = dr;  bus.d_we_i = dw; bus.d_addr_i = da; bus.d_wdata_i = dwd;
    @(negedge clk);
    e_gi = 0; e_gd = 0; e_re = 0; e_we = 0; e_iv = 0; e_dv = 0; e_busy = 0; win_d = 0;
    e_addr = 0; e_data = 0; e_ird = 0; e_drd = 0;
    if (!r) begin
      if (m_pend) begin
        e_busy = 1;
        if (m_own_d) begin e_dv = 1; e_drd = m_data; end
        else         begin e_iv = 1; e_ird = m_data; end
      end else if (ir || dr) begin
`ifdef MEM_ARBITER_RR_EN
        win_d = dr && (!ir || !m_last_d);
`else
        win_d = dr;
`endif
        if (win_d) begin e_gd = 1; e_addr = da; e_data = dwd; e_we = dw; e_re = !dw; end
        else       begin e_gi = 1; e_addr = ia; e_re = 1; end
      end
    end
    check("if_gnt",    bus.if_gnt_o,       e_gi);
    check("d_gnt",     bus.d_gnt_o,        e_gd);
    check("rd_en",     bus.mem_read_en_o,  e_re);
    check("wr_en",     bus.mem_write_en_o, e_we);
    check("mem_addr",  bus.mem_addr_o,     e_addr);
    check("mem_data",  bus.mem_data_o,     e_data);
    check("if_rvalid", bus.if_rvalid_o,    e_iv);
    check("if_rdata",  bus.if_rdata_o,     e_ird);
    check("d_rvalid",  bus.d_rvalid_o,     e_dv);
    check("d_rdata",   bus.d_rdata_o,      e_drd);
    check("busy",      bus.busy_o,         e_busy);
    if (r) begin
      m_pend = 0; m_own_d = 0; m_last_d = 1;
    end else if (m_pend) begin
      m_pend = 0;
    end else if (e_gi || e_gd) begin
      m_last_d = e_gd;
      if (e_we) shadow[da[9:2]] = dwd;
      else begin m_pend = 1; m_own_d = e_gd; m_data = shadow[e_addr[9:2]]; end
    end
    gi = e_gi;
    gd = e_gd;
  endtask

  function automatic logic [31:0] raddr();
    return BASE + 32'($urandom_range(0, 15)) * 4;
  endfunction

  initial begin
    bit gi, gd, ip, dp, dwe, r;
    logic [31:0] ia, da, dwd;
    rst = 1; mem_load = 1;
    bus.if_req_i = 0; bus.if_addr_i = 0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    m_pend = 0; m_own_d = 0; m_last_d = 1; m_data = 0;
    @(posedge clk); #1 mem_load = 0;

    // Reset with requests asserted: nothing may be granted
    cycle(1, 1, BASE, 1, 0, BASE, 0, gi, gd);
    cycle(1, 1, BASE, 1, 1, BASE, 32'h1, gi, gd);

    // Fetch only: grant, data, grant, data
    repeat (4) cycle(0, 1, BASE, 0, 0, 0, 0, gi, gd);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Store then load back the same word
    cycle(0, 0, 0, 1, 1, BASE + 32'h100, 32'hDEADBEEF, gi, gd);
    cycle(0, 0, 0, 1, 0, BASE + 32'h100, 0, gi, gd);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Contention from reset, then data drops out
    cycle(1, 0, 0, 0, 0, 0, 0, gi, gd);
    repeat (8) cycle(0, 1, BASE + 32'h4, 1, 0, BASE + 32'h100, 0, gi, gd);
    repeat (3) cycle(0, 1, BASE + 32'h4, 0, 0, 0, 0, gi, gd);

    // Reset during the response cycle drops the read
    cycle(0, 1, BASE, 0, 0, 0, 0, gi, gd);
    cycle(1, 0, 0, 0, 0, 0, 0, gi, gd);
    cycle(0, 1, BASE + 32'h8, 0, 0, 0, 0, gi, gd);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Data request withdrawn while a fetch is outstanding
    cycle(0, 1, BASE, 0, 0, 0, 0, gi, gd);
    cycle(0, 0, 0, 1, 1, BASE + 32'h10, 32'hCAFEF00D, gi, gd);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
    cycle(0, 0, 0, 1, 0, BASE + 32'h10, 0, gi, gd);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Random traffic: requests held until granted, occasional withdrawal and reset
    ip = 0; dp = 0; dwe = 0; ia = BASE; da = BASE; dwd = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!ip && $urandom_range(0, 3) != 0) begin ip = 1; ia = raddr(); end
      else if (ip && $urandom_range(0, 15) == 0) ip = 0;
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; da = raddr(); dwe = bit'($urandom_range(0, 1)); dwd = $urandom;
      end else if (dp && $urandom_range(0, 15) == 0) dp = 0;
      r = ($urandom_range(0, 63) == 0);
      cycle(r, ip, ia, dp, dwe, da, dwd, gi, gd);
      if (gi) ip = 0;
      if (gd) dp = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
